// File: rtl/exec_bypass_alu_pkg.sv
// Shared definitions for the execute stage (exec_bypass_alu).
// Holds the opcode and aluop constants, the ALU operation enum, the
// forwarding select encodings and the register-writer predicate.
package exec_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] ALUOP_ADD = 5'b00000;
  localparam logic [4:0] ALUOP_SUB = 5'b00001;
  localparam logic [4:0] ALUOP_AND = 5'b00010;
  localparam logic [4:0] ALUOP_OR  = 5'b00011;
  localparam logic [4:0] ALUOP_SLL = 5'b00100;
  localparam logic [4:0] ALUOP_SRA = 5'b00101;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLL,
    ALU_SRA,
    ALU_NONE
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_XM = 2'd0,
    SEL_MW = 2'd1,
    SEL_RF = 2'd2
  } sel_e;

  // Opcodes that write their rd field back to the register file.
  function automatic logic is_writer(input logic [4:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_JAL) ||
           (op == OP_SETX)  || (op == OP_LW);
  endfunction

endpackage

// File: rtl/exec_bypass_alu_if.sv
// Signal bundle between the pipeline registers and the execute stage.
// master: pipeline side (drives DX/XM/MW state, observes execute outputs).
// slave : the execute stage itself.
interface exec_bypass_alu_if;
  logic [31:0] dx_ir;
  logic [31:0] dx_pc;
  logic [31:0] dx_a;
  logic [31:0] dx_b;
  logic [31:0] xm_ir;
  logic [31:0] xm_o;
  logic [31:0] mw_ir;
  logic [31:0] mw_data;
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic        sel_dmem;
  logic [31:0] br_target;
  logic [31:0] res_q;
  logic [31:0] b_q;
  logic        ne_q;
  logic        lt_q;
  logic        ovf_q;

  modport master (
    output dx_ir, dx_pc, dx_a, dx_b, xm_ir, xm_o, mw_ir, mw_data,
    input  sel_a, sel_b, sel_dmem, br_target, res_q, b_q, ne_q, lt_q, ovf_q
  );

  modport slave (
    input  dx_ir, dx_pc, dx_a, dx_b, xm_ir, xm_o, mw_ir, mw_data,
    output sel_a, sel_b, sel_dmem, br_target, res_q, b_q, ne_q, lt_q, ovf_q
  );
endinterface

// File: rtl/exec_bypass_alu_alu_core.sv
// alu_core: combinational 32-bit ALU.
// Ports: a, b (operands), op (alu_op_e), shamt (shift amount)
//        -> result, ne (a-b != 0), lt (signed a<b), ovf (add/sub overflow).
module alu_core
  import exec_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        ne,
  output logic        lt,
  output logic        ovf
);

  function automatic logic [31:0] ripple_add(input logic [31:0] x, input logic [31:0] y,
                                             input logic cin);
    logic        c;
    logic [31:0] s;
    c = cin;
    for (int unsigned i = 0; i < 32; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  logic [31:0] sum;
  logic [31:0] diff;
  logic        ovf_add;
  logic        ovf_sub;

  always_comb begin
    sum     = ripple_add(a, b, 1'b0);
    diff    = ripple_add(a, ~b, 1'b1);
    ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
    ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);
    // Flags always come from a-b; the overflow term restores the true sign.
    ne      = |diff;
    lt      = diff[31] ^ ovf_sub;
    result  = '0;
    ovf     = 1'b0;
    case (op)
      ALU_ADD: begin result = sum;  ovf = ovf_add; end
      ALU_SUB: begin result = diff; ovf = ovf_sub; end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << shamt;
      ALU_SRA: result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_bypass_alu.sv
// exec_bypass_alu: execute stage of the 5-stage pipeline.
// Forwarding control, operand muxing, ALU and branch-target adder; registers
// ALU result, store data and flags toward XM.
// Ports: clock, reset (sync, active-high), bus (exec_bypass_alu_if.slave).
// Macro EXEC_BYPASS_EN: enables XM/MW forwarding; when undefined the operand
// selects are fixed to the register file and sel_dmem is fixed to 1.
module exec_bypass_alu
  import exec_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  exec_bypass_alu_if.slave   bus
);

  logic [4:0]  dx_op, dx_rd, dx_rs, dx_rt, dx_sh, dx_aluop, src_b;
  logic [31:0] imm_sext;
  sel_e        sel_a_v, sel_b_v;
  logic        sel_dmem_v;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
  alu_op_e     alu_op;
  logic        alu_ne, alu_lt, alu_ovf;
  logic        unused_bits;

  assign dx_op    = bus.dx_ir[31:27];
  assign dx_rd    = bus.dx_ir[26:22];
  assign dx_rs    = bus.dx_ir[21:17];
  assign dx_rt    = bus.dx_ir[16:12];
  assign dx_sh    = bus.dx_ir[11:7];
  assign dx_aluop = bus.dx_ir[6:2];
  assign src_b    = ((dx_op == OP_SW) || (dx_op == OP_BNE) || (dx_op == OP_BLT)) ? dx_rd : dx_rt;
  assign imm_sext = {{15{bus.dx_ir[16]}}, bus.dx_ir[16:0]};
  assign bus.br_target = bus.dx_pc + imm_sext;

`ifdef EXEC_BYPASS_EN
  logic [4:0] xm_op, xm_rd, mw_op, mw_rd;
  logic       xm_wr, mw_wr;

  assign xm_op = bus.xm_ir[31:27];
  assign xm_rd = bus.xm_ir[26:22];
  assign mw_op = bus.mw_ir[31:27];
  assign mw_rd = bus.mw_ir[26:22];
  assign xm_wr = is_writer(xm_op) && (xm_rd != '0);
  assign mw_wr = is_writer(mw_op) && (mw_rd != '0);

  function automatic sel_e fwd_sel(input logic [4:0] src, input logic xw, input logic [4:0] xd,
                                   input logic mwv, input logic [4:0] md);
    if (xw && (xd == src))   return SEL_XM;
    if (mwv && (md == src))  return SEL_MW;
    return SEL_RF;
  endfunction

  assign sel_a_v     = fwd_sel(dx_rs, xm_wr, xm_rd, mw_wr, mw_rd);
  assign sel_b_v     = fwd_sel(src_b, xm_wr, xm_rd, mw_wr, mw_rd);
  assign sel_dmem_v  = !((xm_op == OP_SW) && mw_wr && (mw_rd == xm_rd));
  assign unused_bits = ^{bus.dx_ir[1:0], bus.xm_ir[21:0], bus.mw_ir[21:0]};
`else
  assign sel_a_v     = SEL_RF;
  assign sel_b_v     = SEL_RF;
  assign sel_dmem_v  = 1'b1;
  assign unused_bits = ^{bus.dx_ir[1:0], bus.xm_ir, bus.mw_ir};
`endif

  assign bus.sel_a    = sel_a_v;
  assign bus.sel_b    = sel_b_v;
  assign bus.sel_dmem = sel_dmem_v;

  always_comb begin
    case (sel_a_v)
      SEL_XM:  fwd_a = bus.xm_o;
      SEL_MW:  fwd_a = bus.mw_data;
      default: fwd_a = bus.dx_a;
    endcase
    case (sel_b_v)
      SEL_XM:  fwd_b = bus.xm_o;
      SEL_MW:  fwd_b = bus.mw_data;
      default: fwd_b = bus.dx_b;
    endcase
  end

  // Immediate ops and branches override the ALU op; every other opcode
  // (R-type and the non-ALU ones) is decoded from the aluop field.
  always_comb begin
    alu_b  = fwd_b;
    alu_op = ALU_NONE;
    if ((dx_op == OP_ADDI) || (dx_op == OP_SW) || (dx_op == OP_LW)) begin
      alu_b  = imm_sext;
      alu_op = ALU_ADD;
    end else if ((dx_op == OP_BNE) || (dx_op == OP_BLT)) begin
      alu_op = ALU_SUB;
    end else begin
      case (dx_aluop)
        ALUOP_ADD: alu_op = ALU_ADD;
        ALUOP_SUB: alu_op = ALU_SUB;
        ALUOP_AND: alu_op = ALU_AND;
        ALUOP_OR:  alu_op = ALU_OR;
        ALUOP_SLL: alu_op = ALU_SLL;
        ALUOP_SRA: alu_op = ALU_SRA;
        default:   alu_op = ALU_NONE;
      endcase
    end
  end

  alu_core u_alu (
    .a      (fwd_a),
    .b      (alu_b),
    .op     (alu_op),
    .shamt  (dx_sh),
    .result (alu_res),
    .ne     (alu_ne),
    .lt     (alu_lt),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.res_q <= '0;
      bus.b_q   <= '0;
      bus.ne_q  <= 1'b0;
      bus.lt_q  <= 1'b0;
      bus.ovf_q <= 1'b0;
    end else begin
      bus.res_q <= alu_res;
      bus.b_q   <= fwd_b;
      bus.ne_q  <= alu_ne;
      bus.lt_q  <= alu_lt;
      bus.ovf_q <= alu_ovf;
    end
  end

endmodule

// File: tb/tb_exec_bypass_alu.sv
module tb_exec_bypass_alu;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

`ifdef EXEC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  exec_bypass_alu_if bus ();

  exec_bypass_alu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        sel_dmem;
    logic [31:0] br;
    logic [31:0] res;
    logic [31:0] b;
    logic        ne;
    logic        lt;
    logic        ovf;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit hits(input logic [31:0] ir, input logic [4:0] r);
    int op;
    op = int'(ir[31:27]);
    return (op == 0 || op == 3 || op == 5 || op == 8 || op == 21) &&
           (ir[26:22] != 5'd0) && (ir[26:22] == r);
  endfunction

  function automatic int pick(input logic [4:0] r);
    if (BYP && hits(bus.xm_ir, r)) return 0;
    if (BYP && hits(bus.mw_ir, r)) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] value(input int s, input logic [31:0] rf);
    if (s == 0) return bus.xm_o;
    if (s == 1) return bus.mw_data;
    return rf;
  endfunction

  function automatic exp_t model();
    exp_t        e;
    logic [31:0] ir, a, bf, bo, imm;
    int          op, k, sa, sb;
    longint      wide;
    ir  = bus.dx_ir;
    op  = int'(ir[31:27]);
    sa  = pick(ir[21:17]);
    sb  = pick((op == 7 || op == 2 || op == 6) ? ir[26:22] : ir[16:12]);
    e.sel_a = 2'(sa);
    e.sel_b = 2'(sb);
    a   = value(sa, bus.dx_a);
    bf  = value(sb, bus.dx_b);
    imm = {{15{ir[16]}}, ir[16:0]};
    e.br = bus.dx_pc + imm;
    e.sel_dmem = !(BYP && bus.xm_ir[31:27] == 5'd7 && hits(bus.mw_ir, bus.xm_ir[26:22]));
    e.b = bf;
    bo  = bf;
    if (op == 5 || op == 7 || op == 8) begin bo = imm; k = 0; end
    else if (op == 2 || op == 6) k = 1;
    else k = int'(ir[6:2]);
    e.ovf = 1'b0;
    case (k)
      0: begin
        e.res = a + bo;
        wide = longint'($signed(a)) + longint'($signed(bo));
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      1: begin
        e.res = a - bo;
        wide = longint'($signed(a)) - longint'($signed(bo));
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      2: e.res = a & bo;
      3: e.res = a | bo;
      4: e.res = a << ir[11:7];
      5: e.res = $unsigned($signed(a) >>> ir[11:7]);
      default: e.res = 32'd0;
    endcase
    e.ne = (a != bo);
    e.lt = ($signed(a) < $signed(bo));
    return e;
  endfunction

  // ---------------- compare process ----------------
  exp_t regexp;
  bit   have = 1'b0;

  always @(posedge clock) begin
    if (reset) regexp <= '0;
    else       regexp <= model();
    have <= 1'b1;
  end

  always @(negedge clock) begin
    exp_t c;
    c = model();
    chk("sel_a",     32'(bus.sel_a),    32'(c.sel_a));
    chk("sel_b",     32'(bus.sel_b),    32'(c.sel_b));
    chk("sel_dmem",  32'(bus.sel_dmem), 32'(c.sel_dmem));
    chk("br_target", bus.br_target,     c.br);
    if (have) begin
      chk("res_q", bus.res_q,       regexp.res);
      chk("b_q",   bus.b_q,         regexp.b);
      chk("ne_q",  32'(bus.ne_q),   32'(regexp.ne));
      chk("lt_q",  32'(bus.lt_q),   32'(regexp.lt));
      chk("ovf_q", 32'(bus.ovf_q),  32'(regexp.ovf));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt,
                                     input int sh, input int alu);
    return {op[4:0], rd[4:0], rs[4:0], rt[4:0], sh[4:0], alu[4:0], 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rd, input int rs, input int imm);
    return {op[4:0], rd[4:0], rs[4:0], imm[16:0]};
  endfunction

  task automatic setin(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] xir, input logic [31:0] xo,
                       input logic [31:0] mir, input logic [31:0] md);
    bus.dx_ir = ir;  bus.dx_pc = pc;  bus.dx_a = a;    bus.dx_b = b;
    bus.xm_ir = xir; bus.xm_o = xo;   bus.mw_ir = mir; bus.mw_data = md;
  endtask

  function automatic logic [31:0] rand_ir();
    int ops [11] = '{0, 0, 0, 5, 7, 8, 2, 6, 3, 21, 31};
    return mk(ops[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 7));
  endfunction

  initial begin
    setin('0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    chk("lit_reset_res", bus.res_q, 32'd0);
    chk("lit_reset_b",   bus.b_q,   32'd0);
    chk("lit_reset_ovf", 32'(bus.ovf_q), 32'd0);
    reset = 1'b0;

    // XM add $3 (xm_o=5); DX add $4,$3,$3
    setin(mk(0, 4, 3, 3, 0, 0), 0, 100, 100, mk(0, 3, 1, 2, 0, 0), 5, 0, 0);
    #1;
    chk("lit_fwd_sel_a", 32'(bus.sel_a), BYP ? 32'd0 : 32'd2);
    chk("lit_fwd_sel_b", 32'(bus.sel_b), BYP ? 32'd0 : 32'd2);
    @(posedge clock); #1;
    chk("lit_fwd_res", bus.res_q, BYP ? 32'd10 : 32'd200);

    // XM beats MW on the same register
    setin(mk(0, 4, 3, 0, 0, 0), 0, 100, 0, mk(0, 3, 1, 2, 0, 0), 9, mk_i(5, 3, 0, 7), 7);
    #1;
    chk("lit_prio_sel_a", 32'(bus.sel_a), BYP ? 32'd0 : 32'd2);
    @(posedge clock); #1;
    chk("lit_prio_res", bus.res_q, BYP ? 32'd9 : 32'd100);

    // $0 never forwards
    setin(mk(0, 4, 0, 0, 0, 0), 0, 1, 2, mk(0, 0, 1, 1, 0, 0), 55, mk_i(5, 0, 0, 3), 66);
    #1;
    chk("lit_r0_sel_a", 32'(bus.sel_a), 32'd2);
    chk("lit_r0_sel_b", 32'(bus.sel_b), 32'd2);

    // add overflow
    setin(mk(0, 1, 2, 3, 0, 0), 0, 32'h7FFFFFFF, 1, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("lit_ovf_res", bus.res_q, 32'h80000000);
    chk("lit_ovf_flag", 32'(bus.ovf_q), 32'd1);

    // sub -1 - 1
    setin(mk(0, 1, 2, 3, 0, 1), 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("lit_sub_lt", 32'(bus.lt_q), 32'd1);
    chk("lit_sub_ne", 32'(bus.ne_q), 32'd1);
    chk("lit_sub_res", bus.res_q, 32'hFFFFFFFE);

    // sra by 4
    setin(mk(0, 1, 2, 3, 4, 5), 0, 32'h80000000, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("lit_sra", bus.res_q, 32'hF8000000);

    // XM sw $5, MW lw $5; DX nop
    setin(0, 0, 0, 0, mk(7, 5, 1, 2, 0, 0), 0, mk_i(8, 5, 1, 0), 0);
    #1;
    chk("lit_sel_dmem", 32'(bus.sel_dmem), BYP ? 32'd0 : 32'd1);
    @(posedge clock); #1;
    chk("lit_nop_res", bus.res_q, 32'd0);

    // addi with imm=-1, pc=10
    setin(mk_i(5, 2, 1, 'h1FFFF), 10, 20, 0, 0, 0, 0, 0);
    #1;
    chk("lit_br_target", bus.br_target, 32'd9);
    @(posedge clock); #1;
    chk("lit_addi_res", bus.res_q, 32'd19);

    // reset during a valid add
    setin(mk(0, 1, 2, 3, 0, 0), 0, 4, 5, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("lit_rst_res", bus.res_q, 32'd0);
    chk("lit_rst_b",   bus.b_q,   32'd0);
    reset = 1'b0;

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 400; i++) begin
      setin(rand_ir(), $urandom, $urandom, $urandom, rand_ir(), $urandom, rand_ir(), $urandom);
      reset = ($urandom_range(0, 29) == 0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    @(posedge clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
